// File: rtl/inst_encode_if.sv
// inst_encode_if: field-input and word-output handshake bundle for inst_encode.
interface inst_encode_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 12
);
    logic                          in_valid;
    logic                          in_ready;
    logic [6:0]                    opcode_i;
    logic [4:0]                    rd_i;
    logic [4:0]                    rs1_i;
    logic [4:0]                    rs2_i;
    logic [2:0]                    fun3_i;
    logic [6:0]                    fun7_i;
    logic [31:0]                   imm_i;
    logic                          out_valid;
    logic                          out_ready;
    logic [31:0]                   instruction_o;
    logic [ADDR_W-1:0]             addr_o;
    logic                          err_o;
    logic [$clog2(FIFO_DEPTH):0]   count_o;

    modport slave (
        input  in_valid, opcode_i, rd_i, rs1_i, rs2_i, fun3_i, fun7_i, imm_i, out_ready,
        output in_ready, out_valid, instruction_o, addr_o, err_o, count_o
    );

    modport master (
        output in_valid, opcode_i, rd_i, rs1_i, rs2_i, fun3_i, fun7_i, imm_i, out_ready,
        input  in_ready, out_valid, instruction_o, addr_o, err_o, count_o
    );
endinterface

// File: rtl/inst_encode.sv
// inst_encode: packs decoded RV32I fields into machine words behind an addressed output FIFO.
// Define ENCODE_RANGE_CHECK_EN to also flag immediates that do not fit their encoding field.
module inst_encode #(
    parameter int N_param    = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 12,
    parameter int BASE_ADDR  = 0
) (
    input logic          i_clk,
    input logic          i_rst,
    inst_encode_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [N_param-1:0] NOOP = N_param'(32'h0000_0013);

    logic [N_param:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_q, rd_q;
    logic [CW-1:0]       count_q, count_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [N_param-1:0]  enc_word;
    logic                enc_bad_op, imm_ovf, enc_err;
    logic                push, pop, full, empty;
    logic                fits12, fits13, fits21;
    logic [31:0]         imm;
    logic [6:0]          op;
    logic [2:0]          f3;

    assign imm = bus.imm_i;
    assign op  = bus.opcode_i;
    assign f3  = bus.fun3_i;

    // an immediate fits n signed bits when every bit from n-1 upward matches the sign
    assign fits12 = &imm[31:11] | ~|imm[31:11];
    assign fits13 = &imm[31:12] | ~|imm[31:12];
    assign fits21 = &imm[31:20] | ~|imm[31:20];

    always_comb begin
        enc_word   = NOOP;
        enc_bad_op = 1'b0;
        imm_ovf    = 1'b0;
        case (op)
            7'b0110011: enc_word = {bus.fun7_i, bus.rs2_i, bus.rs1_i, f3, bus.rd_i, op};
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                enc_word = (op == 7'b0010011 && f3[1:0] == 2'b01)
                         ? {bus.fun7_i, imm[4:0], bus.rs1_i, f3, bus.rd_i, op}
                         : {imm[11:0], bus.rs1_i, f3, bus.rd_i, op};
                imm_ovf  = !fits12;
            end
            7'b0100011: begin
                enc_word = {imm[11:5], bus.rs2_i, bus.rs1_i, f3, imm[4:0], op};
                imm_ovf  = !fits12;
            end
            7'b1100011: begin
                enc_word = {imm[12], imm[10:5], bus.rs2_i, bus.rs1_i, f3, imm[4:1], imm[11], op};
                imm_ovf  = !fits13 || imm[0];
            end
            7'b0110111, 7'b0010111: begin
                enc_word = {imm[31:12], bus.rd_i, op};
                imm_ovf  = |imm[11:0];
            end
            7'b1101111: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd_i, op};
                imm_ovf  = !fits21 || imm[0];
            end
            default: enc_bad_op = 1'b1;
        endcase
    end

`ifdef ENCODE_RANGE_CHECK_EN
    assign enc_err = enc_bad_op | imm_ovf;
`else
    logic unused_ovf;
    assign unused_ovf = imm_ovf;
    assign enc_err    = enc_bad_op;
`endif

    assign full    = count_q == CW'(FIFO_DEPTH);
    assign empty   = count_q == '0;
    assign push    = bus.in_valid && !full;
    assign pop     = !empty && bus.out_ready;
    assign count_d = count_q + CW'(push) - CW'(pop);

    assign bus.in_ready      = !full;
    assign bus.out_valid     = !empty;
    assign bus.instruction_o = empty ? NOOP : mem_q[rd_q][N_param-1:0];
    assign bus.err_o         = !empty && mem_q[rd_q][N_param];
    assign bus.count_o       = count_q;
    assign bus.addr_o        = addr_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            addr_q  <= ADDR_W'(BASE_ADDR);
        end else begin
            if (push) wr_q <= wr_q + PW'(1);
            if (pop) begin
                rd_q   <= rd_q + PW'(1);
                addr_q <= addr_q + ADDR_W'(4);
            end
            count_q <= count_d;
        end
    end

    // storage needs no reset: the empty flag masks stale entries
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_q] <= {enc_err, enc_word};
    end
endmodule

// File: tb/tb_inst_encode.sv
// tb_inst_encode: randomized and directed checks of inst_encode against an arithmetic encoding model.
module tb_inst_encode;
    localparam int DEPTH = 4;
    localparam int AW    = 12;
    localparam int BASE  = 0;
`ifdef ENCODE_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    inst_encode_if #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) bus();
    inst_encode #(.N_param(32), .FIFO_DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    logic [32:0]   q[$];
    logic [AW-1:0] exp_addr;

    function automatic logic [32:0] model_enc(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                              logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7,
                                              logic [31:0] imm);
        logic [31:0] o, d, a, b, f, g, w;
        int s;
        bit ok, bad;
        o = 32'(op); d = 32'(rd); a = 32'(rs1); b = 32'(rs2); f = 32'(f3); g = 32'(f7);
        s = $signed(imm);
        ok = 1'b1;
        bad = 1'b0;
        w = 32'h13;
        case (op)
            7'h33: w = (g << 25) | (b << 20) | (a << 15) | (f << 12) | (d << 7) | o;
            7'h13, 7'h03, 7'h67, 7'h73: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5))
                    w = (g << 25) | ((imm & 32'h1F) << 20) | (a << 15) | (f << 12) | (d << 7) | o;
                else
                    w = ((imm & 32'hFFF) << 20) | (a << 15) | (f << 12) | (d << 7) | o;
                ok = s >= -2048 && s <= 2047;
            end
            7'h23: begin
                w = (((imm >> 5) & 32'h7F) << 25) | (b << 20) | (a << 15) | (f << 12)
                  | ((imm & 32'h1F) << 7) | o;
                ok = s >= -2048 && s <= 2047;
            end
            7'h63: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (b << 20) | (a << 15)
                  | (f << 12) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | o;
                ok = s >= -4096 && s <= 4095 && (imm & 1) == 0;
            end
            7'h37, 7'h17: begin
                w = (imm & 32'hFFFF_F000) | (d << 7) | o;
                ok = (imm & 32'hFFF) == 0;
            end
            7'h6F: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (d << 7) | o;
                ok = s >= -(1 << 20) && s < (1 << 20) && (imm & 1) == 0;
            end
            default: bad = 1'b1;
        endcase
        return {bad | (RANGE_CHK & !ok), w};
    endfunction

    task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm);
        bus.opcode_i = op; bus.rd_i = rd; bus.rs1_i = rs1; bus.rs2_i = rs2;
        bus.fun3_i = f3; bus.fun7_i = f7; bus.imm_i = imm;
    endtask

    // advance one clock and update the reference queue from the pre-edge handshake
    task automatic tick();
        logic [32:0] enc;
        bit push, pop;
        enc  = model_enc(bus.opcode_i, bus.rd_i, bus.rs1_i, bus.rs2_i, bus.fun3_i, bus.fun7_i, bus.imm_i);
        push = bus.in_valid && q.size() < DEPTH;
        pop  = bus.out_ready && q.size() > 0;
        @(posedge i_clk);
        #1;
        if (pop) begin
            void'(q.pop_front());
            exp_addr = exp_addr + AW'(4);
        end
        if (push) q.push_back(enc);
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_fields(7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        q.delete();
        exp_addr = AW'(BASE);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.instruction_o !== 32'h13) begin errors++; $display("FAIL reset_instr got=%h exp=00000013", bus.instruction_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err_o); end
        checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count_o); end
        checks++; if (bus.addr_o !== AW'(BASE)) begin errors++; $display("FAIL reset_addr got=%h exp=%h", bus.addr_o, AW'(BASE)); end
    endtask

    task automatic test_fill_drain();
        logic [31:0] w;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_fields(7'h13, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k + 1));
            bus.in_valid = 1'b1;
            if (k < 4) tick();
        end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", bus.count_o); end
        tick();
        checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL full_refuse_count got=%0d exp=4", bus.count_o); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w = (32'(i + 1) << 20) | (32'(i + 1) << 7) | 32'h13;
            checks++; if (bus.out_valid !== 1'b1 || bus.instruction_o !== w) begin
                errors++; $display("FAIL drain_word%0d got=%h/%b exp=%h/1", i, bus.instruction_o, bus.out_valid, w);
            end
            checks++; if (bus.addr_o !== AW'(BASE + 4 * i)) begin
                errors++; $display("FAIL drain_addr%0d got=%h exp=%h", i, bus.addr_o, AW'(BASE + 4 * i));
            end
            if (i == 1) begin
                checks++; if (bus.in_ready !== 1'b1 || bus.count_o !== 3'd3) begin
                    errors++; $display("FAIL after_pop_ready got=%b/%0d exp=1/3", bus.in_ready, bus.count_o);
                end
            end
            tick();
            if (i == 1) bus.in_valid = 1'b0;
        end
        checks++; if (bus.out_valid !== 1'b0 || bus.instruction_o !== 32'h13 || bus.addr_o !== AW'(BASE + 20)) begin
            errors++; $display("FAIL empty_after_drain got=%b/%h/%h exp=0/00000013/%h", bus.out_valid, bus.instruction_o, bus.addr_o, AW'(BASE + 20));
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_vectors();
        logic [6:0]  ops [4] = '{7'h33, 7'h13, 7'h63, 7'h6F};
        logic [4:0]  rds [4] = '{5'd3, 5'd1, 5'd0, 5'd1};
        logic [4:0]  r1s [4] = '{5'd1, 5'd0, 5'd1, 5'd0};
        logic [4:0]  r2s [4] = '{5'd2, 5'd0, 5'd2, 5'd0};
        logic [31:0] ims [4] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'd8};
        logic [31:0] exw [4] = '{32'h0020_81B3, 32'hFFF0_0093, 32'hFE20_8EE3, 32'h0080_00EF};
        for (int i = 0; i < 4; i++) begin
            set_fields(ops[i], rds[i], r1s[i], r2s[i], 3'd0, 7'd0, ims[i]);
            bus.in_valid = 1'b1;
            bus.out_ready = 1'b0;
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_pre_valid got=%b exp=0", i, bus.out_valid); end
            tick();
            bus.in_valid = 1'b0;
            checks++; if (bus.out_valid !== 1'b1 || bus.instruction_o !== exw[i] || bus.err_o !== 1'b0) begin
                errors++; $display("FAIL vec%0d got=%b/%h/%b exp=1/%h/0", i, bus.out_valid, bus.instruction_o, bus.err_o, exw[i]);
            end
            checks++; if (bus.addr_o !== exp_addr) begin errors++; $display("FAIL vec%0d_addr got=%h exp=%h", i, bus.addr_o, exp_addr); end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_invalid_and_range();
        set_fields(7'h7F, 5'd5, 5'd6, 5'd7, 3'd2, 7'd9, 32'h1234);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        checks++; if (bus.instruction_o !== 32'h13 || bus.err_o !== 1'b1) begin
            errors++; $display("FAIL bad_opcode got=%h/%b exp=00000013/1", bus.instruction_o, bus.err_o);
        end
        set_fields(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        checks++; if (bus.instruction_o !== 32'h8000_0093 || bus.err_o !== RANGE_CHK) begin
            errors++; $display("FAIL imm_range got=%h/%b exp=80000093/%b", bus.instruction_o, bus.err_o, RANGE_CHK);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_fields(7'h37, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k + 1) << 12);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.count_o !== 3'd2) begin errors++; $display("FAIL pre_reset_count got=%0d exp=2", bus.count_o); end
        bus.in_valid = 1'b1;
        i_rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.count_o !== 3'd0 || bus.addr_o !== AW'(BASE)) begin
            errors++; $display("FAIL mid_reset got=%b/%0d/%h exp=0/0/%h", bus.out_valid, bus.count_o, bus.addr_o, AW'(BASE));
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        q.delete();
        exp_addr = AW'(BASE);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        checks++; if (bus.count_o !== 3'd0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset got=%0d/%b exp=0/1", bus.count_o, bus.in_ready);
        end
        set_fields(7'h17, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.instruction_o !== 32'hABCD_E497 || bus.addr_o !== AW'(BASE)) begin
            errors++; $display("FAIL post_reset_word got=%b/%h/%h exp=1/abcde497/%h", bus.out_valid, bus.instruction_o, bus.addr_o, AW'(BASE));
        end
        drain();
    endtask

    task automatic test_random();
        logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
        logic [31:0] imm;
        logic [31:0] exp_w;
        logic exp_e;
        for (int c = 0; c < 400; c++) begin
            exp_w = q.size() > 0 ? q[0][31:0] : 32'h13;
            exp_e = q.size() > 0 ? q[0][32] : 1'b0;
            checks++; if (bus.out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.out_valid, q.size() > 0); end
            checks++; if (bus.in_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.in_ready, q.size() < DEPTH); end
            checks++; if (bus.count_o !== 3'(q.size())) begin errors++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, bus.count_o, q.size()); end
            checks++; if (bus.instruction_o !== exp_w) begin errors++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", c, bus.instruction_o, exp_w); end
            checks++; if (bus.err_o !== exp_e) begin errors++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, bus.err_o, exp_e); end
            checks++; if (bus.addr_o !== exp_addr) begin errors++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, bus.addr_o, exp_addr); end
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
                2: imm = $urandom & 32'hFFFF_F000;
                default: imm = 32'($signed($urandom_range(0, 4095)) - 2048) & 32'hFFFF_FFFE;
            endcase
            set_fields(ops[$urandom_range(0, 10)], 5'($urandom), 5'($urandom), 5'($urandom),
                       3'($urandom), 7'($urandom), imm);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_vectors();
        test_invalid_and_range();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
